reg_port_arbiter: RTL and testbench
===================================

REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: req1  input  1  write request, requester 1.
REQ-004 SHALL have port: wdata1  input  16  write data, requester 1; held stable while req1 high.
REQ-005 SHALL have port: req2  input  1  write request, requester 2.
REQ-006 SHALL have port: wdata2  input  16  write data, requester 2; held stable while req2 high.
REQ-007 SHALL have port: rd_req  input  1  read request; level, one read per cycle held.
REQ-008 SHALL have port: gnt1  output  1  registered one-cycle pulse; wdata1 accepted at the edge that raised it.
REQ-009 SHALL have port: gnt2  output  1  as gnt1, for requester 2.
REQ-010 SHALL have port: rd_data  output  16  stored value returned by a read.
REQ-011 SHALL have port: rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.

Function
REQ-012 SHALL hold one 16-bit storage register (stor) shared by both write requesters and the read port.
REQ-013 SHALL make exactly one decision per rising edge: READ, WRITE1, WRITE2 or IDLE; the outcome is visible on outputs the cycle after that edge.
REQ-014 SHALL treat a request as eligible only if reqN=1 and gntN=0 at the edge, so a requester dropping req after seeing gnt is never granted twice.
REQ-015 SHALL keep a 3-bit starvation counter (starve); "force_write" = (starve==4) and a write is eligible.
REQ-016 SHALL choose READ when rd_req=1 and not force_write: rd_data<=stor (pre-edge value), rd_valid<=1, gnt1/gnt2<=0.
REQ-017 SHALL, on READ, increment starve (saturating at 4) when any write is eligible; otherwise clear it.
REQ-018 SHALL choose WRITE when READ is not chosen and at least one write is eligible; a sole eligible requester wins.
REQ-019 SHALL break ties with a 1-bit round-robin pointer rr (0 = requester 1 preferred); after any WRITEk, rr points to the other requester.
REQ-020 SHALL, on WRITEk: stor<=wdatak, gntk<=1, other gnt<=0, rd_valid<=0, starve<=0.
REQ-021 SHALL, on IDLE: gnt1/gnt2/rd_valid<=0, starve<=0, stor and rr unchanged.
REQ-022 SHALL hold rd_data at its last value when not reading; it is never X.
REQ-023 SHALL return data written at edge N to a READ decided at edge N+1 (no bypass; read-after-write latency 1 decision).

Reset
REQ-024 SHALL, while rst=1, immediately force stor=0, rd_data=0, rd_valid=0, gnt1=0, gnt2=0, rr=0, starve=0.
REQ-025 SHALL abandon any in-flight transaction on reset; a write whose gnt was not yet asserted is lost; the requester re-requests.
REQ-026 SHALL make its first decision at the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro ARB_WR_COUNT_EN is defined, add output wr_count (8 bits) counting accepted writes (both ports), reset 0, wrapping 255->0, incremented at the WRITE edge.
REQ-028 SHALL, when ARB_WR_COUNT_EN is undefined, omit the wr_count port and counter entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then req1=1, wdata1=16'hA5A5 -> gnt1 pulse next cycle; then rd_req=1 -> rd_valid=1, rd_data=16'hA5A5.
REQ-030 SHALL cover: req1 and req2 held high, wdata1=16'h0001, wdata2=16'h0002, no reads -> grants alternate 1,2,1,2; each requester drops req after gnt, so 2 grants total.
REQ-031 SHALL cover: rd_req held high, req2=1 from cycle 0 -> 4 READ pulses, then gnt2 on the 5th decision, then reads resume.
REQ-032 SHALL cover: write 16'h1234 at edge N, rd_req=1 for edge N+1 -> rd_data=16'h1234; rd_data then holds 16'h1234 through subsequent IDLE cycles.
REQ-033 SHALL cover: rst asserted mid-cycle between a req1 edge and its gnt -> gnt1, rd_valid, rd_data drop to 0 immediately; stor reads back 16'h0000.
REQ-034 SHALL cover, with ARB_WR_COUNT_EN: 257 accepted writes -> wr_count=1; without the macro the bench elaborates with no wr_count port.

Source files
------------

// File: rtl/reg_port_arbiter.sv
// Two-writer / one-reader arbiter around a single 16-bit register.
// Define ARB_WR_COUNT_EN to add the wr_count accepted-write counter.
module reg_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req1,
  input  logic [15:0] wdata1,
  input  logic        req2,
  input  logic [15:0] wdata2,
  input  logic        rd_req,
  output logic        gnt1,
  output logic        gnt2,
  output logic [15:0] rd_data,
  output logic        rd_valid
`ifdef ARB_WR_COUNT_EN
  ,
  output logic [7:0]  wr_count
`endif
);

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_READ,
    DEC_WR1,
    DEC_WR2
  } dec_e;

  logic [15:0] stor_q, stor_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        gnt1_q, gnt1_d;
  logic        gnt2_q, gnt2_d;
  logic        rr_q, rr_d;
  logic [2:0]  starve_q, starve_d;

  logic elig1, elig2, any_wr;
  logic force_wr;
  logic do_rd, do_w1, do_w2;
  dec_e dec;

  // A requester still holding req in its grant cycle is not re-granted.
  assign elig1    = req1 & ~gnt1_q;
  assign elig2    = req2 & ~gnt2_q;
  assign any_wr   = elig1 | elig2;
  assign force_wr = (starve_q == 3'd4) & any_wr;

  assign do_rd = rd_req & ~force_wr;
  assign do_w1 = ~do_rd & elig1 & (~elig2 | ~rr_q);
  assign do_w2 = ~do_rd & elig2 & (~elig1 | rr_q);

  always_comb begin
    dec = DEC_IDLE;
    unique case (1'b1)
      do_rd:   dec = DEC_READ;
      do_w1:   dec = DEC_WR1;
      do_w2:   dec = DEC_WR2;
      default: dec = DEC_IDLE;
    endcase
  end

  always_comb begin
    stor_d     = stor_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    gnt1_d     = 1'b0;
    gnt2_d     = 1'b0;
    rr_d       = rr_q;
    starve_d   = 3'd0;
    unique case (dec)
      DEC_READ: begin
        rd_data_d  = stor_q;
        rd_valid_d = 1'b1;
        if (any_wr)
          starve_d = (starve_q == 3'd4) ? 3'd4
                                        : starve_q + 3'd1;
      end
      DEC_WR1: begin
        stor_d = wdata1;
        gnt1_d = 1'b1;
        rr_d   = 1'b1;
      end
      DEC_WR2: begin
        stor_d = wdata2;
        gnt2_d = 1'b1;
        rr_d   = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stor_q     <= 16'h0000;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
      gnt1_q     <= 1'b0;
      gnt2_q     <= 1'b0;
      rr_q       <= 1'b0;
      starve_q   <= 3'd0;
    end else begin
      stor_q     <= stor_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      gnt1_q     <= gnt1_d;
      gnt2_q     <= gnt2_d;
      rr_q       <= rr_d;
      starve_q   <= starve_d;
    end
  end

  assign gnt1     = gnt1_q;
  assign gnt2     = gnt2_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef ARB_WR_COUNT_EN
  logic [7:0] wr_count_q, wr_count_d;

  always_comb begin
    wr_count_d = wr_count_q;
    if (do_w1 | do_w2)
      wr_count_d = wr_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_count_q <= 8'd0;
    else     wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter: vector table plus
// starvation, reset and (with ARB_WR_COUNT_EN) write-count sequences.
module tb_reg_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1, req2, rd_req;
  logic [15:0] wdata1, wdata2;
  logic        gnt1, gnt2, rd_valid;
  logic [15:0] rd_data;
`ifdef ARB_WR_COUNT_EN
  logic [7:0]  wr_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req1     (req1),
    .wdata1   (wdata1),
    .req2     (req2),
    .wdata2   (wdata2),
    .rd_req   (rd_req),
    .gnt1     (gnt1),
    .gnt2     (gnt2),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef ARB_WR_COUNT_EN
    ,
    .wr_count (wr_count)
`endif
  );

  typedef struct {
    logic        r1;
    logic [15:0] d1;
    logic        r2;
    logic [15:0] d2;
    logic        rd;
    logic        g1;
    logic        g2;
    logic        rv;
    logic [15:0] rdd;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic g1,
                         input logic g2, input logic rv,
                         input logic [15:0] rdd);
    chk({nm, ".gnt1"}, {15'd0, gnt1}, {15'd0, g1});
    chk({nm, ".gnt2"}, {15'd0, gnt2}, {15'd0, g2});
    chk({nm, ".rd_valid"}, {15'd0, rd_valid}, {15'd0, rv});
    chk({nm, ".rd_data"}, rd_data, rdd);
  endtask

  task automatic drive(input logic r1, input logic [15:0] d1,
                       input logic r2, input logic [15:0] d2,
                       input logic rd);
    req1 = r1; wdata1 = d1;
    req2 = r2; wdata2 = d2;
    rd_req = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 16'hA5A5, 0, 16'h0000, 0, 1, 0, 0, 16'h0000};
    tbl[1]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 16'hA5A5};
    tbl[2]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'hA5A5};
    tbl[3]  = '{0, 16'h0000, 1, 16'h5A5A, 0, 0, 1, 0, 16'hA5A5};
    tbl[4]  = '{1, 16'h0001, 1, 16'h0002, 0, 1, 0, 0, 16'hA5A5};
    tbl[5]  = '{1, 16'h0001, 1, 16'h0002, 0, 0, 1, 0, 16'hA5A5};
    tbl[6]  = '{0, 16'h0000, 1, 16'h0002, 0, 0, 0, 0, 16'hA5A5};
    tbl[7]  = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'hA5A5};
    tbl[8]  = '{0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 16'h0002};
    tbl[9]  = '{1, 16'h1234, 0, 16'h0000, 0, 1, 0, 0, 16'h0002};
    tbl[10] = '{0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 16'h1234};
    tbl[11] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h1234};
    tbl[12] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h1234};
    tbl[13] = '{1, 16'hBBBB, 1, 16'hCCCC, 0, 0, 1, 0, 16'h1234};
    tbl[14] = '{1, 16'hBBBB, 1, 16'hCCCC, 0, 1, 0, 0, 16'h1234};
    tbl[15] = '{0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h1234};
    tbl[16] = '{0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 16'hBBBB};
    tbl[17] = '{1, 16'hDDDD, 0, 16'h0000, 1, 0, 0, 1, 16'hBBBB};
    tbl[18] = '{1, 16'hDDDD, 0, 16'h0000, 0, 1, 0, 0, 16'hBBBB};
    tbl[19] = '{0, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 16'hDDDD};

    rst = 1'b1;
    drive(0, 16'h0000, 0, 16'h0000, 0);
    step();
    step();
    chk_out("reset", 0, 0, 0, 16'h0000);
`ifdef ARB_WR_COUNT_EN
    chk("reset.wr_count", {8'd0, wr_count}, 16'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r1, tbl[i].d1, tbl[i].r2, tbl[i].d2, tbl[i].rd);
      step();
      chk_out($sformatf("vec%0d", i),
              tbl[i].g1, tbl[i].g2, tbl[i].rv, tbl[i].rdd);
    end

    // Read held against a pending write: four reads, then forced write.
    drive(0, 16'h0000, 1, 16'h7777, 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_out($sformatf("starve%0d", i), 0, 0, 1, 16'hDDDD);
    end
    step();
    chk_out("starve5", 0, 1, 0, 16'hDDDD);
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    chk_out("starve6", 0, 0, 1, 16'h7777);

    // Reset in the middle of a grant cycle.
    drive(1, 16'hEEEE, 0, 16'h0000, 0);
    step();
    chk_out("pre_rst", 1, 0, 0, 16'h7777);
    #2;
    rst = 1'b1;
    #1;
    chk_out("mid_rst", 0, 0, 0, 16'h0000);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    step();
    rst = 1'b0;
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    chk_out("post_rst_rd", 0, 0, 1, 16'h0000);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    step();
    chk_out("post_rst_idle", 0, 0, 0, 16'h0000);

    // Both writers held: one accepted write per cycle, alternating.
`ifdef ARB_WR_COUNT_EN
    chk("cnt0.wr_count", {8'd0, wr_count}, 16'd0);
`endif
    drive(1, 16'h0101, 1, 16'h0202, 0);
    for (int i = 0; i < 257; i++) begin
      step();
      if (i < 4)
        chk_out($sformatf("alt%0d", i),
                (i % 2) == 0, (i % 2) == 1, 0, 16'h0000);
    end
    drive(0, 16'h0000, 0, 16'h0000, 0);
`ifdef ARB_WR_COUNT_EN
    chk("cnt257.wr_count", {8'd0, wr_count}, 16'd1);
`endif
    step();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    step();
    chk_out("alt_rd", 0, 0, 1, 16'h0101);
    drive(0, 16'h0000, 0, 16'h0000, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
